// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: FSM encoding and sizes.
package rr_arbiter8_pkg;

    localparam int NREQ   = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Rotating-priority encoder: first set request bit at or after ptr, wrapping 7 -> 0.
module rr_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Index arithmetic is SEL_W wide, so ptr + i wraps naturally.
            k = ptr + SEL_W'(i);
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with bounded hold time, a mandatory idle bubble between
// grants, and a combinational data path that forwards the granted requester's din bit.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  din,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             y,
    output state_e           dbg_state
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    state_d    = BUSY;
                    gnt_d      = NREQ'(1) << pick_idx;
                    sel_d      = pick_idx;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            BUSY: begin
                // Dropped request and exhausted hold share one release path.
                if (!req[sel_q] || hold_cnt_q == HOLD_LIM) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
    assign y         = busy_q ? din[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: a vector table for single-cycle arbitration
// steps, plus hand-written sequences for hold limit, async reset and release corner.
module tb_rr_arbiter8;
    import rr_arbiter8_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [7:0]       req;
    logic [7:0]       din;
    logic [7:0]       gnt;
    logic [2:0]       sel;
    logic             busy;
    logic             y;
    state_e           dbg_state;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter8 #(.HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .y         (y),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string name, input logic [7:0] e_gnt,
                             input logic [2:0] e_sel, input logic e_busy, input logic e_y);
        checks++;
        if (gnt !== e_gnt || sel !== e_sel || busy !== e_busy || y !== e_y ||
            dbg_state !== (e_busy ? BUSY : IDLE)) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b y=%b state=%0d, want gnt=%h sel=%0d busy=%b y=%b",
                     name, gnt, sel, busy, y, dbg_state, e_gnt, e_sel, e_busy, e_y);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        din   = 8'hFF;
        #1;
        check_out("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] d);
        req = r;
        din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_vec(input logic [7:0] r, input logic [7:0] d, input logic [7:0] g,
                           input logic [2:0] s, input logic b, input logic yy);
        vec_t v;
        v.req = r; v.din = d; v.gnt = g; v.sel = s; v.busy = b; v.y = yy;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        din    = 8'h00;

        //      req    din    gnt    sel   busy  y
        for (int i = 0; i < 5; i++)
            add_vec(8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);   // idle after reset
        add_vec(8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0);       // pulse on req[2]
        add_vec(8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0);       // release, ptr -> 3
        add_vec(8'h09, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);       // ptr 3 beats bit 0
        add_vec(8'h01, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0);       // req[3] dropped, ptr -> 4
        add_vec(8'h21, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);       // scan 4,5 -> 5; y = din[5]
        add_vec(8'h20, 8'hDF, 8'h20, 3'd5, 1'b1, 1'b0);       // held, din[5] = 0
        add_vec(8'h00, 8'hFF, 8'h00, 3'd5, 1'b0, 1'b0);       // released, y masked
        add_vec(8'h41, 8'h00, 8'h40, 3'd6, 1'b1, 1'b0);       // ptr 6
        add_vec(8'h01, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0);       // release, ptr -> 7
        add_vec(8'h03, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);       // wrap 7 -> 0
        add_vec(8'h02, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);       // release, ptr -> 1
        add_vec(8'h03, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1);       // ptr 1 beats bit 0
        add_vec(8'hFF, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1);       // other bits ignored while busy
        add_vec(8'hFD, 8'h02, 8'h00, 3'd1, 1'b0, 1'b0);       // only req[sel] matters
        add_vec(8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0);       // idle keeps sel

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].din);
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].y);
        end

        // Continuous 8'h81: two full holds of 8 cycles with one bubble each
        do_reset();
        for (int c = 0; c < 19; c++) begin
            logic [7:0] eg;
            logic [2:0] es;
            logic       eb;
            if (c < 8)       begin eg = 8'h01; es = 3'd0; eb = 1'b1; end
            else if (c == 8) begin eg = 8'h00; es = 3'd0; eb = 1'b0; end
            else if (c < 17) begin eg = 8'h80; es = 3'd7; eb = 1'b1; end
            else if (c == 17) begin eg = 8'h00; es = 3'd7; eb = 1'b0; end
            else             begin eg = 8'h01; es = 3'd0; eb = 1'b1; end
            step(8'h81, 8'h80);
            check_out($sformatf("hold81_c%0d", c), eg, es, eb, eb & (es == 3'd7));
        end

        // Async reset mid-grant, then restart from ptr 0
        do_reset();
        step(8'h08, 8'h00);
        check_out("grant3", 8'h08, 3'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("grant3_async_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 8'h01);
        check_out("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b1);

        // req[sel] drops on the same edge the hold limit is reached
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(8'h04, 8'h00);
            check_out($sformatf("dual_hold_c%0d", c), 8'h04, 3'd2, 1'b1, 1'b0);
        end
        step(8'hFB, 8'h00);
        check_out("dual_release", 8'h00, 3'd2, 1'b0, 1'b0);
        step(8'hFB, 8'h08);
        check_out("dual_next_ptr3", 8'h08, 3'd3, 1'b1, 1'b1);
        step(8'h00, 8'h00);
        check_out("dual_idle", 8'h00, 3'd3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
